// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall controller for a 6-stage in-order core.
// Arbitrates load-use (ID), multi-cycle execute (EX) and data-bus wait (MEM)
// hazards into a per-stage hold vector. It also tracks multi-cycle EX ops
// with a small FSM and raises a sticky flag when a bus wait runs too long.
// Optional build macro: PIPE_CTRL_STAT_EN adds per-source stall-cycle counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_cycles,
  input  logic        stallreq_from_mem,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic        ex_mc_done,
  output logic        bus_timeout
`ifdef PIPE_CTRL_STAT_EN
  ,
  output logic [31:0] stat_id,
  output logic [31:0] stat_ex,
  output logic [31:0] stat_mem
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LIM   = 8'(MEM_TIMEOUT);
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_ID  = 6'b000111;

  state_t     state;
  logic [5:0] cnt;
  logic       done_q;
  logic [7:0] mem_wait;
  logic [7:0] mem_wait_nxt;

  logic [5:0] n_eff;
  logic [5:0] ld_val;
  logic       accept;
  logic       ex_act;
  logic       mem_win;
  logic       ex_win;
  logic       id_win;

  // A zero cycle count still occupies EX for one cycle.
  assign n_eff  = (ex_mc_cycles == 6'd0) ? 6'd1 : ex_mc_cycles;
  assign ld_val = n_eff - 6'd1;

  // A start is taken only from IDLE, and never while the bus is waiting or on flush.
  assign accept = (state == IDLE) & ex_mc_start & ~stallreq_from_mem & ~flush;
  assign ex_act = (state == BUSY) | accept;

  // Priority mem > ex > id; flush and reset suppress every source.
  assign mem_win = rst & ~flush & stallreq_from_mem;
  assign ex_win  = rst & ~flush & ~stallreq_from_mem & ex_act;
  assign id_win  = rst & ~flush & ~stallreq_from_mem & ~ex_act & stallreq_from_id;

  // Hold vector: combinational so the pipeline registers act on it at the next edge.
  always_comb begin
    stall = 6'b000000;
    if (mem_win)     stall = STALL_MEM;
    else if (ex_win) stall = STALL_EX;
    else if (id_win) stall = STALL_ID;
  end

  // Done is registered with the DONE state but masked by a same-cycle flush.
  assign ex_mc_done = done_q & ~flush;

  // Multi-cycle EX tracker: load count on accept, count down while the bus is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      done_q <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            cnt <= ld_val;
            if (ld_val != 6'd0) begin
              state <= BUSY;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!stallreq_from_mem) begin
            if (cnt <= 6'd1) begin
              cnt    <= 6'd0;
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= 6'd0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating length of the current bus-wait streak.
  always_comb begin
    mem_wait_nxt = 8'd0;
    if (stallreq_from_mem)
      mem_wait_nxt = (mem_wait == 8'hFF) ? 8'hFF : mem_wait + 8'd1;
  end

  // Wait counter and sticky timeout; the mem stall keeps being honored after timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wait    <= 8'd0;
      bus_timeout <= 1'b0;
    end else begin
      mem_wait <= mem_wait_nxt;
      if (stallreq_from_mem && (mem_wait_nxt == TO_LIM))
        bus_timeout <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_STAT_EN
  // Per-source stall-cycle counters, credited only to the winning source; wrap freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_id  <= 32'd0;
      stat_ex  <= 32'd0;
      stat_mem <= 32'd0;
    end else begin
      if (id_win)  stat_id  <= stat_id  + 32'd1;
      if (ex_win)  stat_ex  <= stat_ex  + 32'd1;
      if (mem_win) stat_mem <= stat_mem + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver pushes the expected per-cycle
// outputs from a behavioural model; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stallreq_from_id = 1'b0;
  logic       ex_mc_start = 1'b0;
  logic [5:0] ex_mc_cycles = 6'd0;
  logic       stallreq_from_mem = 1'b0;
  logic       flush = 1'b0;
  logic [5:0] stall;
  logic       ex_mc_done;
  logic       bus_timeout;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id),
    .ex_mc_start(ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .stallreq_from_mem(stallreq_from_mem),
    .flush(flush),
    .stall(stall),
    .ex_mc_done(ex_mc_done),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] stall;
    logic       done;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  // Model state: EX hold cycles still owed, a done pulse owed, bus-wait streak, timeout.
  int owed   = 0;
  bit done_p = 0;
  int streak = 0;
  bit to_f   = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
  endtask

  // Monitor: compare every presented cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("stall",       {2'b00, stall},      {2'b00, e.stall});
      check("ex_mc_done",  {7'd0, ex_mc_done},  {7'd0, e.done});
      check("bus_timeout", {7'd0, bus_timeout}, {7'd0, e.to});
    end
  end

  // One cycle of stimulus; inputs change 1ns after the rising edge.
  task automatic step(input bit r, input bit id, input bit st, input logic [5:0] n,
                      input bit mem, input bit fl);
    exp_t e;
    bit   ex_act;
    int   nn;
    @(posedge clk);
    #1;
    rst = r; stallreq_from_id = id; ex_mc_start = st; ex_mc_cycles = n;
    stallreq_from_mem = mem; flush = fl;
    if (!r) begin
      e.stall = 6'd0; e.done = 1'b0; e.to = 1'b0;
      owed = 0; done_p = 0; streak = 0; to_f = 0;
    end else begin
      ex_act  = (owed > 0) || (!done_p && st && !mem && !fl);
      e.done  = done_p && !fl;
      e.to    = to_f;
      e.stall = fl ? 6'd0 : mem ? 6'b011111 : ex_act ? 6'b001111 : id ? 6'b000111 : 6'd0;
      streak  = mem ? ((streak < 255) ? streak + 1 : 255) : 0;
      if (streak == TO) to_f = 1;
      if (fl) begin
        owed = 0; done_p = 0;
      end else if (done_p) begin
        done_p = 0;
      end else if (owed > 0) begin
        if (!mem) begin
          owed--;
          if (owed == 0) done_p = 1;
        end
      end else if (st && !mem) begin
        nn = (n == 0) ? 1 : int'(n);
        owed = nn - 1;
        if (owed == 0) done_p = 1;
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 0, 6'd0, 0, 0);
  endtask

  initial begin
    // reset state
    step(0, 0, 0, 6'd0, 0, 0);
    step(0, 1, 1, 6'd3, 1, 0);
    idle(2);
    // single-cycle load-use
    step(1, 1, 0, 6'd0, 0, 0);
    idle(2);
    // 4-cycle op, start ignored while busy
    step(1, 0, 1, 6'd4, 0, 0);
    step(1, 1, 1, 6'd9, 0, 0);
    idle(5);
    // zero-length op
    step(1, 0, 1, 6'd0, 0, 0);
    idle(3);
    // start refused while mem waits, then accepted
    step(1, 0, 1, 6'd2, 1, 0);
    step(1, 0, 1, 6'd2, 0, 0);
    idle(4);
    // N=3 with two mem-wait cycles mid-op
    step(1, 0, 1, 6'd3, 0, 0);
    step(1, 0, 0, 6'd0, 1, 0);
    step(1, 0, 0, 6'd0, 1, 0);
    idle(5);
    // flush during BUSY, then flush exactly on the done cycle
    step(1, 0, 1, 6'd5, 0, 0);
    idle(1);
    step(1, 1, 0, 6'd0, 1, 1);
    idle(3);
    step(1, 0, 1, 6'd2, 0, 0);
    idle(1);
    step(1, 0, 0, 6'd0, 0, 1);
    idle(3);
    // bus timeout after 4 wait edges, sticky after release
    for (int i = 0; i < 6; i++) step(1, 1, 0, 6'd0, 1, 0);
    idle(3);
    // reset asserted mid-BUSY, op abandoned
    step(1, 0, 1, 6'd8, 0, 0);
    idle(2);
    step(0, 0, 0, 6'd0, 0, 0);
    step(1, 0, 0, 6'd0, 0, 0);
    idle(10);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, id, st, mem, fl;
      logic [5:0] n;
      r   = ($urandom_range(0, 199) != 0);
      id  = ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 3) == 0);
      n   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
      mem = ($urandom_range(0, 4) == 0) || (stallreq_from_mem && $urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 29) == 0);
      step(r, id, st, n, mem, fl);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: mem-wait cycle count at which bus_timeout sets; range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 stallreq_from_id  in  1  load-use hazard request from decode.
REQ-005 ex_mc_start  in  1  EX begins a multi-cycle op this cycle.
REQ-006 ex_mc_cycles  in  6  total EX occupancy N of that op; 0 is treated as 1.
REQ-007 stallreq_from_mem  in  1  data-bus wait request.
REQ-008 flush  in  1  pipeline flush; aborts any multi-cycle op.
REQ-009 stall  out  6  per-stage hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = stop.
REQ-010 ex_mc_done  out  1  one-cycle pulse: multi-cycle result valid in EX.
REQ-011 bus_timeout  out  1  sticky mem-wait timeout flag.
REQ-012 stat_id, stat_ex, stat_mem  out  32 each  stall-cycle counters (present only with PIPE_CTRL_STAT_EN).

Function
REQ-013 stall is combinational from the inputs and registered state; the pipeline registers sample it at the next edge.
REQ-014 Stall encodings: mem active 6'b011111; else ex active 6'b001111; else id active 6'b000111; else 6'b000000; priority mem > ex > id.
REQ-015 flush = 1 forces stall = 6'b000000 that cycle, returns FSM to IDLE, clears cnt, and suppresses ex_mc_done.
REQ-016 FSM states: IDLE, BUSY, DONE; 6-bit down-counter cnt.
REQ-017 IDLE: ex_mc_start=1 with stallreq_from_mem=0 and flush=0 makes ex active this cycle; cnt loads max(N,1)-1; next state BUSY if that value is nonzero, else DONE.
REQ-018 ex_mc_start while stallreq_from_mem=1 is not accepted; EX holds the request until it is.
REQ-019 BUSY: ex active; cnt decrements each cycle in which stallreq_from_mem=0 and freezes otherwise; 1->0 transitions to DONE.
REQ-020 DONE: ex inactive; ex_mc_done=1 for exactly one cycle; next state IDLE.
REQ-021 ex_mc_start is ignored in BUSY and DONE.
REQ-022 An accepted N-cycle op with no mem stall keeps stall[3:0] set for exactly N cycles, with ex_mc_done in cycle N+1.
REQ-023 mem-wait counter (8 bit) increments each cycle stallreq_from_mem=1, clears when 0, and saturates at 255.
REQ-024 bus_timeout sets on the edge at which the counter reaches MEM_TIMEOUT and stays set until reset; the mem stall stays honored after timeout.

Reset
REQ-025 rst=0 asynchronously sets: FSM IDLE, cnt 0, mem-wait counter 0, ex_mc_done 0, bus_timeout 0, stat counters 0; stall is 6'b000000 while in reset.
REQ-026 Reset mid-op abandons the op with no ex_mc_done pulse.

Configuration
REQ-027 Macro PIPE_CTRL_STAT_EN defined: stat_id, stat_ex, stat_mem each increment by 1 in every cycle in which their source is the winning stall source, and wrap at 2^32.
REQ-028 PIPE_CTRL_STAT_EN undefined: stat ports and counters are absent; all other behaviour is identical.

Verification
REQ-029 stallreq_from_id=1 for 1 cycle, others 0 -> stall=6'b000111 for that cycle only.
REQ-030 ex_mc_start=1, ex_mc_cycles=4, IDLE -> stall=6'b001111 for 4 cycles, then ex_mc_done=1 for 1 cycle with stall=0.
REQ-031 ex_mc_cycles=0 start -> stall=6'b001111 for 1 cycle, ex_mc_done next cycle.
REQ-032 ex op N=3 with stallreq_from_mem=1 for 2 cycles mid-BUSY -> stall=6'b011111 those 2 cycles, total ex hold 5 cycles, single done pulse.
REQ-033 MEM_TIMEOUT=4, stallreq_from_mem held 6 cycles -> bus_timeout rises after the 4th edge and stays 1 after the request drops; with flush during BUSY -> stall=0, no done pulse.
REQ-034 rst=0 asserted mid-BUSY between edges -> outputs reset immediately; after release, IDLE with no ex_mc_done pulse.
